// File: rtl/slave_fifo_pkg.sv
// Shared types and constants for the slave-FIFO writer family.
package slave_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    // Top nibble of every burst header, lets the host resynchronise.
    localparam logic [3:0] HDR_MARK = 4'hA;

    // FIFOADR encodings of the four FX2 endpoints.
    localparam logic [1:0] EP2_ADDR = 2'b00;
    localparam logic [1:0] EP4_ADDR = 2'b01;
    localparam logic [1:0] EP6_ADDR = 2'b10;
    localparam logic [1:0] EP8_ADDR = 2'b11;

    // Burst header: marker, source channel, number of data words that follow.
    function automatic logic [15:0] pack_header(input logic [3:0] ch, input logic [7:0] len);
        return {HDR_MARK, ch, len};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts just after the last granted index.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // Walk last+1 .. last+N (mod N) and keep the first requester found.
    always_comb begin
        int idx;
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(i_last) + k) % N;
            if (!o_valid && i_req[idx]) begin
                o_valid      = 1'b1;
                o_grant[idx] = 1'b1;
                o_idx        = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/slave_fifo_tx_mux.sv
// Drains N_CH show-ahead channel FIFOs into the FX2 slave FIFO as
// length-tagged bursts, committing partial packets after an idle timeout.
module slave_fifo_tx_mux
    import slave_fifo_pkg::*;
#(
    parameter int         N_CH      = 4,
    parameter int         DATA_W    = 16,
    parameter int         USEDW_W   = 9,
    parameter int         BURST_MAX = 64,
    parameter int         PKT_WORDS = 256,
    parameter int         TIMEOUT   = 1024,
    parameter logic [1:0] EP_ADDR   = EP6_ADDR
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [N_CH*DATA_W-1:0]   ch_data,
    input  logic [N_CH*USEDW_W-1:0]  ch_usedw,
    input  logic [N_CH-1:0]          ch_empty,
    output logic [N_CH-1:0]          ch_rdrq,
    input  logic                     FLAG_FULL,
    output logic [DATA_W-1:0]        FD_OUT,
    output logic                     FD_OE,
    output logic                     SLWR,
    output logic                     SLRD,
    output logic                     SLOE,
    output logic [1:0]               FIFOADR,
    output logic                     PKTEND,
    output logic                     busy
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int WC_W  = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam int IC_W  = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] PKT_LAST   = WC_W'(PKT_WORDS - 1);
    localparam logic [IC_W-1:0] IDLE_LIMIT = IC_W'(TIMEOUT);
    localparam logic [7:0]      BURST_CAP  = 8'(BURST_MAX);

    state_t              r_state,    w_state_next;
    logic [IDX_W-1:0]    r_ptr,      w_ptr_next;
    logic [IDX_W-1:0]    r_ch,       w_ch_next;
    logic [7:0]          r_len,      w_len_next;
    logic [7:0]          r_cnt,      w_cnt_next;
    logic [WC_W-1:0]     r_word_cnt, w_word_cnt_next;
    logic [IC_W-1:0]     r_idle_cnt, w_idle_cnt_next;
    logic                r_slwr,     w_slwr_next;
    logic                r_pktend,   w_pktend_next;
    logic                r_fd_oe,    w_fd_oe_next;
    logic [DATA_W-1:0]   r_fd_out,   w_fd_out_next;
    logic [N_CH-1:0]     w_rdrq;
    logic                w_write;

    logic [DATA_W-1:0]   w_head  [N_CH];
    logic [USEDW_W-1:0]  w_usedw [N_CH];
    logic [USEDW_W-1:0]  w_usedw_sel;
    logic [7:0]          w_len_sel;
    logic [N_CH-1:0]     w_arb_grant;
    logic [IDX_W-1:0]    w_arb_idx;
    logic                w_arb_valid;

    // Split the flat channel buses into per-channel views.
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_unpack
            assign w_head[gi]  = ch_data[gi*DATA_W +: DATA_W];
            assign w_usedw[gi] = ch_usedw[gi*USEDW_W +: USEDW_W];
        end
    endgenerate

    rr_arbiter #(
        .N     (N_CH),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req   (~ch_empty),
        .i_last  (r_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    // Burst length of the granted channel: its occupancy, capped at BURST_MAX.
    always_comb begin
        w_usedw_sel = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_arb_grant[i]) w_usedw_sel = w_usedw_sel | w_usedw[i];
        end
        if (int'(w_usedw_sel) > BURST_MAX) w_len_sel = BURST_CAP;
        else                               w_len_sel = 8'(w_usedw_sel);
    end

    // Next-state and next-output logic; every write updates the packet counters.
    always_comb begin
        w_state_next    = r_state;
        w_ptr_next      = r_ptr;
        w_ch_next       = r_ch;
        w_len_next      = r_len;
        w_cnt_next      = r_cnt;
        w_word_cnt_next = r_word_cnt;
        w_idle_cnt_next = r_idle_cnt;
        w_slwr_next     = 1'b1;
        w_pktend_next   = 1'b1;
        w_fd_oe_next    = r_fd_oe;
        w_fd_out_next   = r_fd_out;
        w_rdrq          = '0;
        w_write         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_fd_oe_next = 1'b0;
                if (w_arb_valid) begin
                    w_ch_next    = w_arb_idx;
                    w_len_next   = w_len_sel;
                    w_cnt_next   = 8'd0;
                    w_fd_oe_next = 1'b1;
                    w_state_next = ST_HEADER;
                end else begin
                    if (r_idle_cnt != IDLE_LIMIT) w_idle_cnt_next = r_idle_cnt + 1'b1;
                    // A packet already closed by a wrap never needs PKTEND.
                    if (r_idle_cnt == IDLE_LIMIT && r_word_cnt != '0) begin
                        w_pktend_next = 1'b0;
                        w_state_next  = ST_COMMIT;
                    end
                end
            end
            ST_HEADER: begin
                if (FLAG_FULL) begin
                    w_slwr_next   = 1'b0;
                    w_fd_out_next = pack_header(4'(r_ch), r_len);
                    w_write       = 1'b1;
                    w_state_next  = ST_DATA;
                end
            end
            ST_DATA: begin
                // An unexpectedly empty channel stalls exactly like a full FX2.
                if (FLAG_FULL && !ch_empty[r_ch]) begin
                    w_rdrq[r_ch]  = 1'b1;
                    w_slwr_next   = 1'b0;
                    w_fd_out_next = w_head[r_ch];
                    w_write       = 1'b1;
                    if (r_cnt == r_len - 8'd1) begin
                        w_ptr_next   = r_ch;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_cnt_next = r_cnt + 8'd1;
                    end
                end
            end
            ST_COMMIT: begin
                w_fd_oe_next    = 1'b0;
                w_word_cnt_next = '0;
                w_idle_cnt_next = '0;
                w_state_next    = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase

        if (w_write) begin
            w_idle_cnt_next = '0;
            w_word_cnt_next = (r_word_cnt == PKT_LAST) ? '0 : r_word_cnt + 1'b1;
        end
    end

    // State and registered pin drivers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_ptr      <= IDX_W'(N_CH - 1);
            r_ch       <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_word_cnt <= '0;
            r_idle_cnt <= '0;
            r_slwr     <= 1'b1;
            r_pktend   <= 1'b1;
            r_fd_oe    <= 1'b0;
            r_fd_out   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_ptr      <= w_ptr_next;
            r_ch       <= w_ch_next;
            r_len      <= w_len_next;
            r_cnt      <= w_cnt_next;
            r_word_cnt <= w_word_cnt_next;
            r_idle_cnt <= w_idle_cnt_next;
            r_slwr     <= w_slwr_next;
            r_pktend   <= w_pktend_next;
            r_fd_oe    <= w_fd_oe_next;
            r_fd_out   <= w_fd_out_next;
        end
    end

    assign ch_rdrq = w_rdrq;
    assign FD_OUT  = r_fd_out;
    assign FD_OE   = r_fd_oe;
    assign SLWR    = r_slwr;
    assign PKTEND  = r_pktend;
    assign SLRD    = 1'b1;
    assign SLOE    = 1'b1;
    assign FIFOADR = EP_ADDR;
    assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_slave_fifo_tx_mux.sv
// Directed bench for slave_fifo_tx_mux with small PKT_WORDS/TIMEOUT.
module tb_slave_fifo_tx_mux;

    localparam int N_CH  = 4;
    localparam int TOUT  = 20;
    localparam int PKTW  = 16;
    localparam int DEPTH = 1024;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 flag_full = 1'b1;
    logic [N_CH*16-1:0]   ch_data;
    logic [N_CH*9-1:0]    ch_usedw;
    logic [N_CH-1:0]      ch_empty;
    logic [N_CH-1:0]      ch_rdrq;
    logic [15:0]          fd_out;
    logic                 fd_oe, slwr, slrd, sloe, pktend, busy;
    logic [1:0]           fifoadr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    slave_fifo_tx_mux #(
        .N_CH(N_CH), .DATA_W(16), .USEDW_W(9), .BURST_MAX(64),
        .PKT_WORDS(PKTW), .TIMEOUT(TOUT), .EP_ADDR(2'b10)
    ) dut (
        .CLK(clk), .RST(rst),
        .ch_data(ch_data), .ch_usedw(ch_usedw), .ch_empty(ch_empty), .ch_rdrq(ch_rdrq),
        .FLAG_FULL(flag_full),
        .FD_OUT(fd_out), .FD_OE(fd_oe), .SLWR(slwr), .SLRD(slrd), .SLOE(sloe),
        .FIFOADR(fifoadr), .PKTEND(pktend), .busy(busy)
    );

    // Show-ahead channel FIFO model.
    logic [15:0] mem [N_CH][DEPTH];
    int wr_ptr [N_CH];
    int rd_ptr [N_CH];

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_fifo
            assign ch_data[gi*16 +: 16] = mem[gi][rd_ptr[gi] % DEPTH];
            assign ch_usedw[gi*9 +: 9]  = 9'(wr_ptr[gi] - rd_ptr[gi]);
            assign ch_empty[gi]         = (wr_ptr[gi] == rd_ptr[gi]);
        end
    endgenerate

    always @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (ch_rdrq[i]) rd_ptr[i] <= rd_ptr[i] + 1;
        end
    end

    // FX2-side monitor: every SLWR-low cycle is a word, every PKTEND-low cycle a commit.
    int          cyc = 0;
    logic        prev_oe = 1'b0;
    int          oe_rise = -1;
    int          oe_fall = -1;
    logic [15:0] wq [$];
    int          wcyc [$];
    int          pq [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!slwr) begin
            wq.push_back(fd_out);
            wcyc.push_back(cyc);
        end
        if (!pktend) pq.push_back(cyc);
        if (fd_oe && !prev_oe) oe_rise <= cyc;
        if (!fd_oe && prev_oe) oe_fall <= cyc;
        prev_oe <= fd_oe;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_seq(input string tag, input logic [15:0] exp [$]);
        check({tag, "_len"}, 32'(wq.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < wq.size(); i++) begin
            check($sformatf("%s_w%0d", tag, i), 32'(wq[i]), 32'(exp[i]));
        end
    endtask

    task automatic push(input int ch, input int n, input logic [15:0] base);
        for (int k = 0; k < n; k++) begin
            mem[ch][wr_ptr[ch] % DEPTH] = base + 16'(k);
            wr_ptr[ch]++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flag_full = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < N_CH; i++) wr_ptr[i] = rd_ptr[i];
        wq.delete();
        wcyc.delete();
        pq.delete();
        rst = 1'b0;
    endtask

    // Wait until the DUT is idle with all channels drained for 3 cycles.
    task automatic wait_quiet(input string tag, input int max);
        int q = 0;
        int n = 0;
        while (q < 3 && n < max) begin
            @(negedge clk);
            n++;
            if (!busy && (&ch_empty) && slwr) q++;
            else q = 0;
        end
        check({tag, "_quiet"}, 32'(q >= 3), 32'd1);
    endtask

    task automatic wait_writes(input string tag, input int cnt, input int max);
        int n = 0;
        while (wq.size() < cnt && n < max) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_reached"}, 32'(wq.size() >= cnt), 32'd1);
    endtask

    initial begin
        logic [15:0] exp [$];
        int c;
        int last;
        int viol;
        int n;
        logic [7:0] blen;

        // Reset values while RST is held.
        @(negedge clk);
        check("rst_slwr",    32'(slwr),    32'd1);
        check("rst_pktend",  32'(pktend),  32'd1);
        check("rst_fd_oe",   32'(fd_oe),   32'd0);
        check("rst_fd_out",  32'(fd_out),  32'd0);
        check("rst_rdrq",    32'(ch_rdrq), 32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("const_pins",  32'({slrd, sloe, fifoadr}), 32'b1110);

        // T1: ch0, 5 words. Header A005 two cycles after the request appears.
        do_reset();
        @(negedge clk);
        push(0, 5, 16'h1100);
        c = cyc;
        wait_quiet("t1", 100);
        exp = '{16'hA005, 16'h1100, 16'h1101, 16'h1102, 16'h1103, 16'h1104};
        check_seq("t1", exp);
        check("t1_oe_rise",   32'(oe_rise), 32'(c + 1));
        check("t1_first_wr",  32'(wcyc[0]), 32'(c + 2));
        check("t1_last_wr",   32'(wcyc[5]), 32'(c + 7));
        check("t1_oe_fall",   32'(oe_fall), 32'(c + 8));

        // T2: ch0 and ch2, 3 words each; pointer at reset favours ch0.
        do_reset();
        @(negedge clk);
        push(0, 3, 16'h2000);
        push(2, 3, 16'h2200);
        wait_quiet("t2", 100);
        exp = '{16'hA003, 16'h2000, 16'h2001, 16'h2002,
                16'hA203, 16'h2200, 16'h2201, 16'h2202};
        check_seq("t2", exp);

        // T3: 200 words on ch1 -> bursts 64, 64, 64, 8 with contiguous data.
        do_reset();
        @(negedge clk);
        push(1, 200, 16'h3000);
        wait_quiet("t3", 1000);
        exp.delete();
        n = 0;
        for (int b = 0; b < 4; b++) begin
            blen = (b < 3) ? 8'd64 : 8'd8;
            exp.push_back({8'hA1, blen});
            for (int k = 0; k < int'(blen); k++) begin
                exp.push_back(16'h3000 + 16'(n));
                n++;
            end
        end
        check_seq("t3", exp);
        check("t3_no_pktend", 32'(pq.size()), 32'd0);

        // T4: FLAG_FULL low for 10 cycles mid-burst on ch2 (20 words).
        do_reset();
        @(negedge clk);
        push(2, 20, 16'h4000);
        wait_writes("t4", 5, 100);
        flag_full = 1'b0;
        viol = 0;
        repeat (10) begin
            @(negedge clk);
            if (!slwr || ch_rdrq != '0) viol++;
        end
        flag_full = 1'b1;
        check("t4_stall_viol", 32'(viol), 32'd0);
        wait_quiet("t4", 100);
        exp.delete();
        exp.push_back(16'hA214);
        for (int k = 0; k < 20; k++) exp.push_back(16'h4000 + 16'(k));
        check_seq("t4", exp);

        // T5: 7 words written then idle. PKTEND lands TIMEOUT edges after the
        // edge that sampled the last word, i.e. TOUT+1 monitor cycles later.
        do_reset();
        @(negedge clk);
        push(3, 6, 16'h5000);
        wait_quiet("t5", 100);
        check("t5_words", 32'(wq.size()), 32'd7);
        last = wcyc[wcyc.size() - 1];
        n = 0;
        while (pq.size() == 0 && n < TOUT + 40) begin
            @(negedge clk);
            n++;
        end
        check("t5_pktend_seen", 32'(pq.size()), 32'd1);
        check("t5_pktend_cyc",  32'(pq[0]), 32'(last + TOUT + 1));
        repeat (3 * TOUT) @(negedge clk);
        check("t5_single_pktend", 32'(pq.size()), 32'd1);

        // T5b: exactly PKT_WORDS words (header + 15) -> auto-commit, no PKTEND.
        do_reset();
        @(negedge clk);
        push(0, 15, 16'h5800);
        wait_quiet("t5b", 100);
        repeat (3 * TOUT) @(negedge clk);
        check("t5b_words",  32'(wq.size()), 32'(PKTW));
        check("t5b_no_pkt", 32'(pq.size()), 32'd0);

        // T6: RST mid-DATA with ptr=2; next burst must come from ch0, not ch3.
        do_reset();
        @(negedge clk);
        push(2, 3, 16'h6200);
        wait_quiet("t6a", 100);
        push(3, 10, 16'h6300);
        wait_writes("t6", 8, 100);
        @(posedge clk);
        #1;
        check("t6_pre_slwr", 32'(slwr), 32'd0);
        rst = 1'b1;
        #1;
        check("t6_rst_pins", 32'({slwr, fd_oe, busy, ch_rdrq}), 32'b1000000);
        push(0, 2, 16'h6000);
        repeat (2) @(negedge clk);
        wq.delete();
        wcyc.delete();
        rst = 1'b0;
        wait_quiet("t6b", 100);
        check("t6_hdr0",  32'(wq[0]), 32'h0000A002);
        check("t6_d0",    32'(wq[1]), 32'h00006000);
        check("t6_d1",    32'(wq[2]), 32'h00006001);
        check("t6_hdr3",  32'(wq[3][15:8]), 32'h000000A3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/slave_fifo_tx_mux.md
# slave_fifo_tx_mux

Parametrised multi-channel successor to the single-channel slave-FIFO writer: drains up to N_CH show-ahead channel FIFOs (one per deserializer link, already in the IFCLK domain) into the Cypress slave FIFO over FD. It serves channels in round-robin order and emits length-tagged bursts. Partial USB packets are committed with PKTEND after an idle timeout. It sits between the per-link dual-clock FIFOs and the FD/SLWR/PKTEND pins at the top level.

## Interface
- N_CH, 4: number of channels (1..16)
- DATA_W, 16: FD width; fixed at 16 by the FX2 16-bit bus
- USEDW_W, 9: width of each channel's used-words count
- BURST_MAX, 64: maximum data words per burst (1..255)
- PKT_WORDS, 256: words per USB packet (512-byte bulk)
- TIMEOUT, 1024: idle cycles before forcing PKTEND on a partial packet
- EP_ADDR, 2'b10: FIFOADR value (EP6 IN)

Ports:
- CLK  in  1  IFCLK domain clock
- RST  in  1  asynchronous, active-high reset
- ch_data  in  N_CH*DATA_W  show-ahead heads, channel i at [i*16 +: 16]
- ch_usedw  in  N_CH*USEDW_W  per-channel occupancy
- ch_empty  in  N_CH  per-channel empty
- ch_rdrq  out  N_CH  pop strobe, one-hot or zero
- FLAG_FULL  in  1  FX2 programmable-full, active-low (0 = no room)
- FD_OUT  out  16  write data; the top drives the FD inout from it
- FD_OE  out  1  FD drive enable
- SLWR  out  1  active-low write strobe
- SLRD  out  1  active-low read strobe; constant 1
- SLOE  out  1  active-low FX2 output enable; constant 1
- FIFOADR  out  2  endpoint select; constant EP_ADDR
- PKTEND  out  1  active-low packet commit
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, HEADER, DATA, COMMIT.
- IDLE: round-robin search starts at ptr+1 (mod N_CH) for the first channel with !ch_empty. If one is found, latch ch, len = min(usedw, BURST_MAX) and go to HEADER. If none is found, increment idle_cnt.
- HEADER: when FLAG_FULL=1, write the header word {4'hA, ch[3:0], len[7:0]} and go to DATA. Otherwise stall.
- DATA: each cycle with FLAG_FULL=1, pop the channel (ch_rdrq[ch]=1) and write the word. After len words: ptr<=ch, return to IDLE. The FLAG_FULL=0 stall holds all state with no pop.
- len never exceeds usedw at latch time, so a burst never sees empty mid-way. If ch_empty rises mid-burst anyway, the block stalls without popping.
- word_cnt counts written words (header and data) mod PKT_WORDS. On wrap the FX2 auto-commits and no PKTEND is issued.
- idle_cnt resets on any write. When idle_cnt reaches TIMEOUT and word_cnt != 0, go to COMMIT.
- COMMIT: PKTEND=0 for exactly one cycle, word_cnt<=0, idle_cnt<=0, then IDLE. It is never issued with word_cnt==0.
- FLAG_FULL is configured in the FX2 with at least 4 words of margin. The block stops within 1 cycle of seeing it low.

## Timing
- Reset values: SLWR=1, PKTEND=1, FD_OE=0, FD_OUT=0, ch_rdrq=0, busy=0, ptr=N_CH-1, counters=0, state IDLE.
- SLWR, FD_OUT, PKTEND and FD_OE are registered. The FX2 samples FD on the rising CLK edge while SLWR=0.
- ch_rdrq is combinational from state/FLAG_FULL/ch_empty. The popped ch_data word appears on FD_OUT in the next cycle with SLWR=0.
- FD_OE rises entering HEADER and falls one cycle after the last SLWR=0.
- Arbitration to header latency: 1 cycle (IDLE decision, header written on the next edge).
- Sustained rate: 1 word/cycle; burst of len costs len+1 cycles plus 1 IDLE cycle.
- Simultaneous wrap and timeout: the wrap wins and word_cnt becomes 0, so no COMMIT.
- RST mid-burst: outputs return to reset values immediately (async). The partial burst is lost; the FX2 side is flushed by firmware.

## Structure
- Package slave_fifo_pkg holds the state enum, HDR_MARK=4'hA, endpoint constants (EP2/4/6/8) and the header-pack function.
- Sub-module rr_arbiter (N_CH request vector, last-grant pointer, one-hot grant plus valid) is reused by the future OUT-direction reader.

## Test plan
- Single channel, 5 words, FLAG_FULL=1 → FD sequence A005, w0..w4, with 6 SLWR=0 cycles.
- Channels 0 and 2 each with 3 words, ptr at reset → header A003 from ch0, then A203.
- One channel, 200 words queued → bursts of len 64, 64, 64, 8 with contiguous data.
- FLAG_FULL low for 10 cycles mid-burst → no pops and SLWR=1 throughout; resumes with no lost or duplicated word.
- 7 words written then idle → PKTEND=0 for one cycle exactly TIMEOUT cycles after the last write. An exact PKT_WORDS total gives no PKTEND.
- RST asserted mid-DATA → SLWR=1 and FD_OE=0 in the same cycle; the next burst starts from ch0.
